// File: rtl/led_link_rx_if.sv
// Signal bundle between the inter-board serial line and the slave LED receiver.
// The master side drives the wire and observes the recovered outputs.
interface led_link_rx_if;
    logic       rx_in;
    logic [7:0] led_out;
    logic       frame_valid;
    logic       frame_err;
    logic       link_alive;

    modport master (
        output rx_in,
        input  led_out,
        input  frame_valid,
        input  frame_err,
        input  link_alive
    );

    modport slave (
        input  rx_in,
        output led_out,
        output frame_valid,
        output frame_err,
        output link_alive
    );
endinterface

// File: rtl/led_link_rx.sv
// 8E1 serial receiver for the inter-board LED link. It recovers each LED byte,
// rejects glitches, parity and framing errors, and blanks the display when the link is silent.
module led_link_rx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    led_link_rx_if.slave link
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state, state_d;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             par_ok;
    logic [TO_W-1:0]  to_cnt, to_next;
    logic             to_expire;

    logic [7:0]       led_q;
    logic             valid_q, err_q, alive_q;

    logic             baud_clr, shift_en, par_en, frame_ok, frame_bad;

    assign rx_s = sync_q[1];

    assign link.led_out     = led_q;
    assign link.frame_valid = valid_q;
    assign link.frame_err   = err_q;
    assign link.link_alive  = alive_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state;
        baud_clr  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    baud_clr = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_TICK) begin
                    baud_clr = 1'b1;
                    state_d  = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == FULL_TICK) begin
                    baud_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (baud_cnt == FULL_TICK) begin
                    baud_clr = 1'b1;
                    par_en   = 1'b1;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == FULL_TICK) begin
                    baud_clr = 1'b1;
                    if (rx_s) begin
                        frame_ok  = par_ok;
                        frame_bad = !par_ok;
                        state_d   = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A good frame restarts the silence counter even on the cycle it would saturate.
    always_comb begin
        to_next   = to_cnt;
        to_expire = 1'b0;
        if (frame_ok) begin
            to_next = '0;
        end else if (to_cnt != TO_MAX) begin
            to_next   = to_cnt + 1'b1;
            to_expire = (to_cnt == TO_MAX - 1'b1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync_q    <= 2'b11;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_ok    <= 1'b0;
            to_cnt    <= TO_MAX;
            led_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            alive_q   <= 1'b0;
        end else begin
            state    <= state_d;
            sync_q   <= {sync_q[0], link.rx_in};
            baud_cnt <= baud_clr ? '0 : baud_cnt + 1'b1;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
            if (par_en)   par_ok    <= ((^shift_reg) == rx_s);

            to_cnt  <= to_next;
            alive_q <= (to_next < TO_MAX);
            valid_q <= frame_ok;
            err_q   <= frame_bad;

            if (frame_ok) begin
                led_q <= shift_reg;
            end else if (to_expire) begin
                led_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_link_rx.sv
// Directed bench for led_link_rx: good, bad-parity, glitch, framing, timeout and
// mid-frame reset cases with hand-computed expectations.
module tb_led_link_rx;

    localparam int CPB = 16;
    localparam int TO  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_link_rx_if link ();

    led_link_rx #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    // Pulse bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (link.frame_valid) fv_cnt++;
        if (link.frame_err)   fe_cnt++;
        if (link.frame_valid && link.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        link.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            link.rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        int fv0, fe0, elapsed;
        logic [7:0] prev_led;
        logic [10:0] bits;

        link.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_led",   32'(link.led_out),     32'h00);
        check("rst_alive", 32'(link.link_alive),  32'h0);
        check("rst_valid", 32'(link.frame_valid), 32'h0);
        check("rst_err",   32'(link.frame_err),   32'h0);

        // Good frame 0xA5, even parity bit 0.
        idle(5);
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(10);
        check("a5_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
        check("a5_err_cnt",   32'(fe_cnt - fe0), 32'd0);
        check("a5_led",       32'(link.led_out), 32'hA5);
        check("a5_alive",     32'(link.link_alive), 32'h1);

        // Bad parity on 0x01.
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(10);
        check("par_err_cnt",   32'(fe_cnt - fe0), 32'd1);
        check("par_valid_cnt", 32'(fv_cnt - fv0), 32'd0);
        check("par_led",       32'(link.led_out), 32'hA5);

        // Short low glitch.
        fv0 = fv_cnt; fe0 = fe_cnt;
        link.rx_in = 1'b0;
        repeat (5) @(negedge clk);
        idle(40);
        check("glitch_err_cnt",   32'(fe_cnt - fe0), 32'd0);
        check("glitch_valid_cnt", 32'(fv_cnt - fv0), 32'd0);
        check("glitch_led",       32'(link.led_out), 32'hA5);

        // Framing error with line held low, then recovery with 0x80.
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        link.rx_in = 1'b0;
        repeat (100) @(negedge clk);
        idle(20);
        check("frm_err_cnt",   32'(fe_cnt - fe0), 32'd1);
        check("frm_valid_cnt", 32'(fv_cnt - fv0), 32'd0);
        check("frm_led",       32'(link.led_out), 32'hA5);
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(8'h80, 1'b1, 1'b1);
        check("x80_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
        check("x80_err_cnt",   32'(fe_cnt - fe0), 32'd0);
        check("x80_led",       32'(link.led_out), 32'h80);

        // Silence until the link times out.
        link.rx_in = 1'b1;
        fe0 = fe_cnt;
        elapsed = 0;
        prev_led = link.led_out;
        while (link.link_alive && elapsed < 2500) begin
            prev_led = link.led_out;
            @(negedge clk);
            elapsed++;
        end
        check("to_fell",        32'(link.link_alive), 32'h0);
        check("to_window",      32'(elapsed >= 1985 && elapsed <= 2000), 32'h1);
        check("to_led_before",  32'(prev_led), 32'h80);
        check("to_led_blank",   32'(link.led_out), 32'h00);
        idle(10);
        check("to_no_err",      32'(fe_cnt - fe0), 32'd0);

        fv0 = fv_cnt;
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(5);
        check("ff_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
        check("ff_led",       32'(link.led_out), 32'hFF);
        check("ff_alive",     32'(link.link_alive), 32'h1);

        // Reset during the 4th data bit (d3) of a 0x55 frame.
        bits = {1'b1, 1'b0, 8'h55, 1'b0};
        for (int i = 0; i < 4; i++) begin
            link.rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
        link.rx_in = bits[4];
        repeat (CPB / 2) @(negedge clk);
        fv0 = fv_cnt; fe0 = fe_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_led",   32'(link.led_out),     32'h00);
        check("mid_rst_alive", 32'(link.link_alive),  32'h0);
        check("mid_rst_valid", 32'(link.frame_valid), 32'h0);
        check("mid_rst_err",   32'(link.frame_err),   32'h0);
        idle(200);
        check("mid_rst_no_pulse", 32'((fv_cnt - fv0) + (fe_cnt - fe0)), 32'd0);
        check("mid_rst_led_hold", 32'(link.led_out), 32'h00);

        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(5);
        check("x55_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
        check("x55_err_cnt",   32'(fe_cnt - fe0), 32'd0);
        check("x55_led",       32'(link.led_out), 32'h55);
        check("x55_alive",     32'(link.link_alive), 32'h1);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/led_link_rx.md
Name: led_link_rx

Overview:
- Slave-board receiver for the inter-board LED link.
- The master board serialises each 8-bit LED slice as an 8E1 frame on one wire. This block recovers the byte and drives the slave's LED display input.
- It rejects glitches and parity/framing errors.
- It blanks the display when the link goes silent, matching the master's all-zero idle state.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (9600 baud at 50 MHz); minimum 4.
- TIMEOUT_CYCLES, 100000000, clk cycles without a valid frame before the link is declared dead (2 s at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- rx_in  input  1  serial line from master, asynchronous, idles high.
- led_out  output  8  last valid received byte; feeds the slave LED display input.
- frame_valid  output  1  one-cycle pulse when led_out is updated from a good frame.
- frame_err  output  1  one-cycle pulse on a parity or stop-bit error.
- link_alive  output  1  high while a valid frame was received within TIMEOUT_CYCLES.

Behaviour:
- Reset values:
  - led_out = 0, frame_valid = 0, frame_err = 0, link_alive = 0.
  - Synchroniser flops = 1.
  - State = IDLE; bit and baud counters = 0.
  - Timeout counter = TIMEOUT_CYCLES (saturated), so link_alive stays low until the first good frame.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only. This gives 2 cycles of input latency.
- Frame format, LSB first: start(0), d0..d7, even parity bit (total count of ones over d0..d7 and parity is even), stop(1).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on rx_s == 0, clear baud counter, go to START.
  - START: sample rx_s when the baud counter reaches CLKS_PER_BIT/2 - 1 (bit centre).
    - 0: clear the counter and go to DATA.
    - 1: glitch; return to IDLE with no error pulse.
  - DATA: sample once every CLKS_PER_BIT cycles into the shift register. After the 8th sample go to PARITY.
  - PARITY: sample after CLKS_PER_BIT cycles, compare against the even parity of the data, latch the result, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit = 1 and parity OK: led_out <= data, frame_valid = 1 for one cycle, timeout counter <= 0, go to IDLE.
    - Stop bit = 1 and parity bad: frame_err = 1, led_out unchanged, go to IDLE.
    - Stop bit = 0 (framing error or break): frame_err = 1, led_out unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents re-sync inside a bad frame.
- Output timing: led_out, frame_valid and frame_err are registered. They change on the clk edge at the stop-bit centre sample and are visible from the following cycle.
- Timeout counter:
  - Increments every cycle it is not cleared; saturates at TIMEOUT_CYCLES (no wrap).
  - link_alive = (counter < TIMEOUT_CYCLES), registered.
  - On the cycle the counter reaches TIMEOUT_CYCLES, led_out is cleared to 0 (display blanks). No frame_err is raised.
- Simultaneous events: if a good stop bit lands on the same cycle the counter would saturate, the good frame wins. led_out takes the new data, the counter is cleared, link_alive stays or returns high.
- rst asserted mid-frame: the partial frame is discarded, all reset values apply, and no pulse is generated.
- frame_valid and frame_err are never high in the same cycle.
- A line held low forever yields exactly one frame_err followed by WAIT_IDLE; there are no repeated errors.

Test Plan:
- CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000. Send 0xA5 with parity 0 and stop 1 → frame_valid one pulse; led_out=0xA5 from the next cycle; link_alive=1.
- Send 0x01 with parity 0 (wrong; 1 expected) → frame_err one pulse; led_out holds 0xA5; frame_valid stays 0.
- Drive rx_in low for 5 cycles, then high → FSM returns to IDLE; no frame_err, no frame_valid; led_out unchanged.
- Send 0x3C with stop bit 0, and hold the line low 100 cycles, then release it and send 0x80 (parity 1) → frame_err exactly once, then frame_valid with led_out=0x80.
- After 0x80, keep the line idle for 2000 cycles → link_alive falls and led_out=0x00 on the same edge. The next good frame 0xFF restores led_out=0xFF and link_alive=1.
- Assert rst at the 4th data bit of a frame for one cycle → all outputs return to reset values and no pulse occurs. The following full frame 0x55 is received correctly.
